// File: rtl/robm_plant_model.sv
// robm_plant_model: plant/environment model answering the robm controller's
// y commands with timed x sensor responses.
//
// Ports:
//   clk          plant clock, rising edge (controller drives cmd on falling edge)
//   rst          asynchronous, active-high reset
//   start        operator start pulse, honoured only while idle
//   route_cfg    route selection latched at start: [6:0] -> x12,x11,x10,x9,x8,x6,x5
//   part_present gripper part-present sense, captured into x2 on y6
//   part_orient  gripper orientation sense, captured into x3 on y6
//   cmd          controller commands, cmd[i] = y(i+1)
//   sens         sensor outputs, sens[i] = x(i+1)
//   pos          arm position, saturating at both ends
//   cycle_cnt    completed work cycles, wraps
//   busy         a work cycle is in progress
//   alarm        sticky silent-controller flag
//
// Build option ROBM_PLANT_RESP_CHECK_EN: when defined, alarm is raised if no
// y1/y2/y4 sample follows a y6 within two samples; otherwise alarm is tied low.
module robm_plant_model #(
   parameter int MOVE_CYCLES  = 6,
   parameter int DWELL_CYCLES = 3,
   parameter int POS_W        = 8,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [6:0]       route_cfg,
   input  logic             part_present,
   input  logic             part_orient,
   input  logic [9:0]       cmd,
   output logic [11:0]      sens,
   output logic [POS_W-1:0] pos,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             busy,
   output logic             alarm
);

   localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES + 1) : 1;
   localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES + 1) : 1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t           state_q, state_d;
   logic [6:0]       route_q, route_d;
   logic             x1_q, x1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_q, req_d;
   logic             mact_q, mact_d;
   logic [MW-1:0]    mcnt_q, mcnt_d;
   logic             dir_q, dir_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             x4_q, x4_d;
   logic             dact_q, dact_d;
   logic [DW-1:0]    dcnt_q, dcnt_d;
   logic             x7_q, x7_d;
   logic             x2_q, x2_d;
   logic             x3_q, x3_d;
   logic             start_go, cyc_done;
   logic             mv_req, mv_go, mv_end, step;
   logic             dv_go, dv_end, grip_clr;
   logic             unused_cmd;

   assign unused_cmd = ^{cmd[9], cmd[7:6]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Start unit: start is only accepted while idle, y5 closes the cycle.
   always_comb begin
      start_go = (state_q == IDLE) && start;
      cyc_done = (state_q == ACTIVE) && cmd[4];
      state_d  = start_go ? ACTIVE : cyc_done ? IDLE : state_q;
   end

   always_comb begin
      route_d  = start_go ? route_cfg : cyc_done ? 7'd0 : route_q;
      // On the setting edge cmd is deliberately ignored.
      x1_d     = start_go ? 1'b1 : (x1_q && cmd != 10'd0) ? 1'b0 : x1_q;
      cnt_d    = cyc_done ? cnt_q + CNT_W'(1) : cnt_q;
      // Move request: y2 with exactly one of y1/y3, edge-detected.
      mv_req   = cmd[1] & (cmd[0] ^ cmd[2]);
      req_d    = mv_req;
      mv_go    = mv_req & ~req_q & ~mact_q;
      // Completion fires on the edge that takes the count to zero, or the
      // first active edge for a zero-length move.
      mv_end   = mact_q && (mcnt_q <= MW'(1));
      step     = mact_q && (mcnt_q != MW'(0));
      mact_d   = mv_go ? 1'b1 : mv_end ? 1'b0 : mact_q;
      mcnt_d   = mv_go ? MW'(MOVE_CYCLES) : step ? mcnt_q - MW'(1) : mcnt_q;
      dir_d    = mv_go ? cmd[2] : dir_q;
      pos_d    = !step ? pos_q :
                 dir_q ? ((pos_q == '0) ? pos_q : pos_q - POS_W'(1)) :
                         ((pos_q == '1) ? pos_q : pos_q + POS_W'(1));
      x4_d     = mv_end ? 1'b1 : cmd[3] ? 1'b0 : x4_q;
      // Dwell: a fresh y9 restarts the count and pre-empts a pending finish.
      dv_go    = cmd[8];
      dv_end   = dact_q && !dv_go && (dcnt_q <= DW'(1));
      dact_d   = dv_go ? 1'b1 : dv_end ? 1'b0 : dact_q;
      dcnt_d   = dv_go ? DW'(DWELL_CYCLES) :
                 (dact_q && dcnt_q != DW'(0)) ? dcnt_q - DW'(1) : dcnt_q;
      x7_d     = dv_end ? 1'b1 : cmd[2] ? 1'b0 : x7_q;
      // Gripper: capture beats clear.
      grip_clr = cmd[0] | cmd[2] | cmd[3];
      x2_d     = cmd[5] ? part_present : grip_clr ? 1'b0 : x2_q;
      x3_d     = cmd[5] ? part_orient : grip_clr ? 1'b0 : x3_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         route_q <= '0;
         x1_q    <= 1'b0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         mact_q  <= 1'b0;
         mcnt_q  <= '0;
         dir_q   <= 1'b0;
         pos_q   <= '0;
         x4_q    <= 1'b0;
         dact_q  <= 1'b0;
         dcnt_q  <= '0;
         x7_q    <= 1'b0;
         x2_q    <= 1'b0;
         x3_q    <= 1'b0;
      end else begin
         route_q <= route_d;
         x1_q    <= x1_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         mact_q  <= mact_d;
         mcnt_q  <= mcnt_d;
         dir_q   <= dir_d;
         pos_q   <= pos_d;
         x4_q    <= x4_d;
         dact_q  <= dact_d;
         dcnt_q  <= dcnt_d;
         x7_q    <= x7_d;
         x2_q    <= x2_d;
         x3_q    <= x3_d;
      end
   end

   assign sens      = {route_q[6:2], x7_q, route_q[1:0], x4_q, x3_q, x2_q, x1_q};
   assign pos       = pos_q;
   assign cycle_cnt = cnt_q;
   assign busy      = (state_q == ACTIVE);

`ifdef ROBM_PLANT_RESP_CHECK_EN
   logic [1:0] win_q, win_d;
   logic       alarm_q, alarm_d;
   logic       resp;

   // Window counts the samples still allowed to carry a response; y6 reopens it.
   always_comb begin
      resp    = cmd[0] | cmd[1] | cmd[3];
      win_d   = cmd[5] ? 2'd2 : (win_q == 2'd0 || resp) ? 2'd0 : win_q - 2'd1;
      alarm_d = alarm_q | (~cmd[5] & ~resp & (win_q == 2'd1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q   <= 2'd0;
         alarm_q <= 1'b0;
      end else begin
         win_q   <= win_d;
         alarm_q <= alarm_d;
      end
   end

   assign alarm = alarm_q;
`else
   assign alarm = 1'b0;
`endif

endmodule
